// File: rtl/lift_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lift_ctrl : three-floor lift sequencer (collective call ordering, door dwell)
// Revision 1.0
// ---------------------------------------------------------------------------
module lift_ctrl #(
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       slowref,
  input  logic [2:0] callbtn,
  output logic [1:0] floorno,
  output logic       dir,
  output logic       moving,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [2:0] floor_mask;
  logic [2:0] above_mask;
  logic [2:0] below_mask;
  logic [2:0] calls;
  logic [2:0] latch_mask;
  logic [2:0] clear_mask;
  logic       here_call;
  logic       recall;
  logic       calls_above;
  logic       calls_below;
  logic       calls_ahead;
  logic       calls_behind;
  logic       enter_door;

  always_comb begin
    floor_mask = 3'b100;
    above_mask = 3'b000;
    below_mask = 3'b011;
    case (floorno)
      2'd0: begin
        floor_mask = 3'b001;
        above_mask = 3'b110;
        below_mask = 3'b000;
      end
      2'd1: begin
        floor_mask = 3'b010;
        above_mask = 3'b100;
        below_mask = 3'b001;
      end
      default: begin
        floor_mask = 3'b100;
        above_mask = 3'b000;
        below_mask = 3'b011;
      end
    endcase

    // Direction decisions see live buttons as well as latched calls.
    calls        = pending | callbtn;
    here_call    = |(calls & floor_mask);
    recall       = |(callbtn & floor_mask);
    calls_above  = |(calls & above_mask);
    calls_below  = |(calls & below_mask);
    calls_ahead  = dir ? calls_above : calls_below;
    calls_behind = dir ? calls_below : calls_above;

    // A call for the current floor is only latched while the car is travelling.
    latch_mask = (state == MOVE) ? 3'b111 : ~floor_mask;
    enter_door = (state == IDLE) && here_call;
    clear_mask = enter_door ? floor_mask : 3'b000;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      cnt       <= '0;
      floorno   <= 2'd0;
      dir       <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      pending   <= 3'b000;
    end else begin
      pending <= (pending | (callbtn & latch_mask)) & ~clear_mask;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (here_call) begin
            state     <= DOOR;
            door_open <= 1'b1;
          end else if (calls_ahead) begin
            state  <= MOVE;
            moving <= 1'b1;
          end else if (calls_behind) begin
            dir    <= ~dir;
            state  <= MOVE;
            moving <= 1'b1;
          end
        end

        MOVE: begin
          if (slowref) begin
            if (cnt == MOVE_LAST) begin
              cnt    <= '0;
              state  <= IDLE;
              moving <= 1'b0;
              if (dir && (floorno != 2'd2)) begin
                floorno <= floorno + 2'd1;
              end else if (!dir && (floorno != 2'd0)) begin
                floorno <= floorno - 2'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        DOOR: begin
          // A re-press at this floor holds the door; it wins over expiry.
          if (recall) begin
            cnt <= '0;
          end else if (slowref) begin
            if (cnt == DOOR_LAST) begin
              cnt       <= '0;
              state     <= IDLE;
              door_open <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_floor_range : assert property (@(posedge clk) disable iff (!resetb) floorno != 2'b11);
  a_one_activity : assert property (@(posedge clk) disable iff (!resetb) !(moving && door_open));
`endif

endmodule
`default_nettype wire
